if_id_skid_reg: RTL and testbench

Parametrised elastic IF/ID pipeline register that replaces the plain stall/clear register. It uses a valid/ready handshake and a 2-entry skid buffer (main + skid), so the fetch side sees a registered ready and never loses an instruction when decode stalls. A flush input squashes all held entries, and the stage then presents a NOP bubble.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 38 +++
 rtl/if_id_skid_reg.sv | 159 +++++++++++++++
 tb/tb_if_id_skid_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF/ID stage.
//   - ifid_state_e : occupancy state of the elastic IF/ID register
//   - DEF_INS_W / DEF_PC_W : default instruction and PC+4 widths
//   - NOP_ENC : default instruction presented while no real instruction is held
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } ifid_state_e;

  localparam int DEF_INS_W = 32;
  localparam int DEF_PC_W  = 30;

  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   i_Clk  : clock, rising edge
//   Reset  : asynchronous, active-low clear
//   i_Inc  : increment this cycle (ignored once the count is all-ones)
//   o_Cnt  : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_Clk,
  input  logic         Reset,
  input  logic         i_Inc,
  output logic [W-1:0] o_Cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID pipeline register with a 2-entry skid buffer (main + skid).
// Fetch sees a ready that is decoded from registered state only, so there is
// no combinational path from decode's ready back to fetch. Entries leave in
// FIFO order: main first, then skid.
//
// Handshake: a transfer happens on a rising edge of i_Clk when valid and
// ready are both 1 on that interface (in: i_Valid & o_Ready, out: o_Valid &
// i_Ready). A producer holding valid must keep its data stable until the
// transfer; both transfers are evaluated on the same edge.
//
// Ports:
//   i_Clk, Reset     : clock (rising edge), async active-low reset
//   i_Flush          : squash every held entry, present a bubble next cycle
//   i_Valid/o_Ready  : fetch side handshake, i_Ins / i_PC4 payload
//   o_Valid/i_Ready  : decode side handshake, o_Ins / o_PC4 payload
//   o_StallCnt       : cycles with o_Valid & ~i_Ready (IFID_PERF_CNT_EN only)
//   o_FlushCnt       : flushes while not EMPTY   (IFID_PERF_CNT_EN only)
//
// Build option: define IFID_PERF_CNT_EN to add the two saturating counters.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int               INS_W   = DEF_INS_W,
  parameter int               PC_W    = DEF_PC_W,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_ENC),
  parameter int               CNT_W   = 16
) (
  input  logic             i_Clk,
  input  logic             Reset,
  input  logic             i_Flush,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [INS_W-1:0] i_Ins,
  input  logic [PC_W-1:0]  i_PC4,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [INS_W-1:0] o_Ins,
  output logic [PC_W-1:0]  o_PC4
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_StallCnt,
  output logic [CNT_W-1:0] o_FlushCnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  ifid_state_e      state_q,    state_d;
  logic [INS_W-1:0] main_ins_q, main_ins_d;
  logic [PC_W-1:0]  main_pc_q,  main_pc_d;
  logic [INS_W-1:0] skid_ins_q, skid_ins_d;
  logic [PC_W-1:0]  skid_pc_q,  skid_pc_d;

  logic in_xfer;
  logic out_xfer;

  // Both handshake outputs decode registered state only.
  assign o_Ready  = (state_q != FULL);
  assign o_Valid  = (state_q != EMPTY);
  assign in_xfer  = i_Valid & o_Ready;
  assign out_xfer = o_Valid & i_Ready;

  always_comb begin
    state_d    = state_q;
    main_ins_d = main_ins_q;
    main_pc_d  = main_pc_q;
    skid_ins_d = skid_ins_q;
    skid_pc_d  = skid_pc_q;

    if (i_Flush) begin
      // Drops any accepted input; an entry consumed by decode on this edge
      // has already left, so only the bubble remains.
      state_d    = EMPTY;
      main_ins_d = NOP_INS;
      main_pc_d  = '0;
      skid_ins_d = '0;
      skid_pc_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_ins_d = i_Ins;
            main_pc_d  = i_PC4;
            state_d    = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_ins_d = i_Ins;
            main_pc_d  = i_PC4;
          end else if (in_xfer) begin
            skid_ins_d = i_Ins;
            skid_pc_d  = i_PC4;
            state_d    = FULL;
          end else if (out_xfer) begin
            main_ins_d = NOP_INS;
            main_pc_d  = '0;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_ins_d = skid_ins_q;
            main_pc_d  = skid_pc_q;
            skid_ins_d = '0;
            skid_pc_d  = '0;
            state_d    = BUSY;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_ins_d = NOP_INS;
          main_pc_d  = '0;
          skid_ins_d = '0;
          skid_pc_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= EMPTY;
      main_ins_q <= NOP_INS;
      main_pc_q  <= '0;
      skid_ins_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_ins_q <= main_ins_d;
      main_pc_q  <= main_pc_d;
      skid_ins_q <= skid_ins_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  // Bubble values are held in the main register, not muxed on the way out.
  assign o_Ins = main_ins_q;
  assign o_PC4 = main_pc_q;

`ifdef IFID_PERF_CNT_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_Clk (i_Clk),
    .Reset (Reset),
    .i_Inc (o_Valid & ~i_Ready),
    .o_Cnt (o_StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_Clk (i_Clk),
    .Reset (Reset),
    .i_Inc (i_Flush & (state_q != EMPTY)),
    .o_Cnt (o_FlushCnt)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

  localparam int INS_W = 32;
  localparam int PC_W  = 30;
  localparam int CNT_W = 4;
  localparam logic [INS_W-1:0] NOP_V = 32'h0000_0000;

  logic             i_Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             i_Flush = 1'b0;
  logic             i_Valid = 1'b0;
  logic             o_Ready;
  logic [INS_W-1:0] i_Ins = '0;
  logic [PC_W-1:0]  i_PC4 = '0;
  logic             o_Valid;
  logic             i_Ready = 1'b0;
  logic [INS_W-1:0] o_Ins;
  logic [PC_W-1:0]  o_PC4;
`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] o_StallCnt;
  logic [CNT_W-1:0] o_FlushCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [INS_W+PC_W-1:0] exp_q[$];

  // Clock / reset block
  always #5 i_Clk = ~i_Clk;

  if_id_skid_reg #(
    .INS_W   (INS_W),
    .PC_W    (PC_W),
    .NOP_INS (NOP_V),
    .CNT_W   (CNT_W)
  ) dut (
    .i_Clk   (i_Clk),
    .Reset   (Reset),
    .i_Flush (i_Flush),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .i_Ins   (i_Ins),
    .i_PC4   (i_PC4),
    .o_Valid (o_Valid),
    .i_Ready (i_Ready),
    .o_Ins   (o_Ins),
    .o_PC4   (o_PC4)
`ifdef IFID_PERF_CNT_EN
    ,
    .o_StallCnt (o_StallCnt),
    .o_FlushCnt (o_FlushCnt)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [INS_W-1:0] ins,
                       input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
    i_Valid = v;
    i_Ins   = ins;
    i_PC4   = pc;
    i_Ready = rdy;
    i_Flush = fl;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #1;
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_Valid); end
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_Ready); end
    n_checks++; if (o_Ins !== NOP_V) begin n_fail++; $display("FAIL reset_ins got %h want %h", o_Ins, NOP_V); end
    n_checks++; if (o_PC4 !== '0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", o_PC4); end
    Reset = 1'b1;
    cyc();
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, INS_W'(k), PC_W'(k * 4), 1'b1, 1'b0);
      cyc();
      n_checks++; if (o_Valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", k, o_Valid); end
      n_checks++; if (o_Ins !== INS_W'(k)) begin n_fail++; $display("FAIL stream_ins[%0d] got %h want %h", k, o_Ins, k); end
      n_checks++; if (o_PC4 !== PC_W'(k * 4)) begin n_fail++; $display("FAIL stream_pc4[%0d] got %h want %h", k, o_PC4, k * 4); end
      n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b want 1", k, o_Ready); end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got %b want 0", o_Valid); end
    n_checks++; if (o_Ins !== NOP_V) begin n_fail++; $display("FAIL stream_drain_ins got %h want %h", o_Ins, NOP_V); end
    n_checks++; if (o_PC4 !== '0) begin n_fail++; $display("FAIL stream_drain_pc4 got %h want 0", o_PC4); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h11, 30'h100, 1'b0, 1'b0);
    cyc();
    n_checks++; if (o_Ins !== 32'h11 || o_Ready !== 1'b1) begin n_fail++; $display("FAIL stall_c1 ins=%h rdy=%b want 11/1", o_Ins, o_Ready); end
    drive(1'b1, 32'h12, 30'h104, 1'b0, 1'b0);
    cyc();
    n_checks++; if (o_Ins !== 32'h11 || o_Ready !== 1'b0) begin n_fail++; $display("FAIL stall_c2 ins=%h rdy=%b want 11/0", o_Ins, o_Ready); end
    drive(1'b1, 32'h13, 30'h108, 1'b0, 1'b0);
    cyc();
    n_checks++; if (o_Ins !== 32'h11 || o_PC4 !== 30'h100 || o_Ready !== 1'b0) begin n_fail++; $display("FAIL stall_c3 ins=%h pc=%h rdy=%b want 11/100/0", o_Ins, o_PC4, o_Ready); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    n_checks++; if (o_Valid !== 1'b1 || o_Ins !== 32'h12 || o_PC4 !== 30'h104) begin n_fail++; $display("FAIL stall_skid_out v=%b ins=%h pc=%h want 1/12/104", o_Valid, o_Ins, o_PC4); end
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_back got %b want 1", o_Ready); end
    cyc();
    n_checks++; if (o_Valid !== 1'b0 || o_Ins !== NOP_V) begin n_fail++; $display("FAIL stall_drain v=%b ins=%h want 0/%h", o_Valid, o_Ins, NOP_V); end
  endtask

  task automatic test_flush_full();
    drive(1'b1, 32'hA, 30'h10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'hB, 30'h14, 1'b0, 1'b0);
    cyc();
    n_checks++; if (o_Ready !== 1'b0 || o_Ins !== 32'hA) begin n_fail++; $display("FAIL flush_setup rdy=%b ins=%h want 0/a", o_Ready, o_Ins); end
    drive(1'b1, 32'hC, 30'h18, 1'b0, 1'b1);
    cyc();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", o_Valid); end
    n_checks++; if (o_Ins !== NOP_V) begin n_fail++; $display("FAIL flush_ins got %h want %h", o_Ins, NOP_V); end
    n_checks++; if (o_PC4 !== '0) begin n_fail++; $display("FAIL flush_pc4 got %h want 0", o_PC4); end
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", o_Ready); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak[%0d] v=%b ins=%h want 0", k, o_Valid, o_Ins); end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h51, 30'h20, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 32'h52, 30'h24, 1'b0, 1'b0);
    cyc();
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", o_Valid); end
    n_checks++; if (o_Ins !== NOP_V) begin n_fail++; $display("FAIL areset_ins got %h want %h", o_Ins, NOP_V); end
    n_checks++; if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready got %b want 1", o_Ready); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    Reset = 1'b1;
    drive(1'b1, 32'h21, 30'h30, 1'b1, 1'b0);
    cyc();
    n_checks++; if (o_Valid !== 1'b1 || o_Ins !== 32'h21 || o_PC4 !== 30'h30) begin n_fail++; $display("FAIL areset_restart v=%b ins=%h pc=%h want 1/21/30", o_Valid, o_Ins, o_PC4); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL areset_drain got %b want 0", o_Valid); end
  endtask

  task automatic test_random();
    int cnt;
    logic [PC_W-1:0] pc;
    logic in_x, out_x;
    logic [INS_W+PC_W-1:0] head;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    exp_q.delete();
    cnt = 0;
    pc  = 30'h1000;
    for (int c = 0; c < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, pc, 1'($urandom_range(0, 1)), 1'b0);
      #3;
      n_checks++; if (o_Ready !== (cnt != 2)) begin n_fail++; $display("FAIL rand_ready[%0d] got %b occ=%0d", c, o_Ready, cnt); end
      n_checks++; if (o_Valid !== (cnt != 0)) begin n_fail++; $display("FAIL rand_valid[%0d] got %b occ=%0d", c, o_Valid, cnt); end
      if (cnt != 0) begin
        head = exp_q[0];
        n_checks++; if ({o_Ins, o_PC4} !== head) begin n_fail++; $display("FAIL rand_data[%0d] got %h/%h want %h/%h", c, o_Ins, o_PC4, head[INS_W+PC_W-1:PC_W], head[PC_W-1:0]); end
      end else begin
        n_checks++; if (o_Ins !== NOP_V || o_PC4 !== '0) begin n_fail++; $display("FAIL rand_bubble[%0d] got %h/%h want %h/0", c, o_Ins, o_PC4, NOP_V); end
      end
      in_x  = i_Valid && (cnt != 2);
      out_x = (cnt != 0) && i_Ready;
      if (out_x) void'(exp_q.pop_front());
      if (in_x) begin
        exp_q.push_back({i_Ins, i_PC4});
        pc = pc + 30'd1;
      end
      cnt = cnt + int'(in_x) - int'(out_x);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    cyc();
    cyc();
    n_checks++; if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain got %b want 0", o_Valid); end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf_cnt();
    #2 Reset = 1'b0;
    #1;
    n_checks++; if (o_StallCnt !== '0 || o_FlushCnt !== '0) begin n_fail++; $display("FAIL perf_reset stall=%0d flush=%0d want 0/0", o_StallCnt, o_FlushCnt); end
    Reset = 1'b1;
    drive(1'b1, 32'h77, 30'h40, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) cyc();
    n_checks++; if (o_StallCnt !== 4'd15) begin n_fail++; $display("FAIL perf_stall_sat got %0d want 15", o_StallCnt); end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 32'h78, 30'h44, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    n_checks++; if (o_FlushCnt !== 4'd2) begin n_fail++; $display("FAIL perf_flush got %0d want 2", o_FlushCnt); end
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    n_checks++; if (o_FlushCnt !== 4'd2) begin n_fail++; $display("FAIL perf_flush_empty got %0d want 2", o_FlushCnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_async_reset();
    test_random();
`ifdef IFID_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
